// File: rtl/traffic_pkg.sv
// Shared types and constants for the traffic-light seconds display path:
// converter states, special BCD codes and 7-segment patterns (bit0 = a .. bit6 = g).
package traffic_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    COMMIT
  } conv_state_t;

  localparam logic [3:0] BCD_DASH  = 4'hA;
  localparam logic [3:0] BCD_BLANK = 4'hF;

  localparam logic [6:0] SEG_0    = 7'h3F;
  localparam logic [6:0] SEG_1    = 7'h06;
  localparam logic [6:0] SEG_2    = 7'h5B;
  localparam logic [6:0] SEG_3    = 7'h4F;
  localparam logic [6:0] SEG_4    = 7'h66;
  localparam logic [6:0] SEG_5    = 7'h6D;
  localparam logic [6:0] SEG_6    = 7'h7D;
  localparam logic [6:0] SEG_7    = 7'h07;
  localparam logic [6:0] SEG_8    = 7'h7F;
  localparam logic [6:0] SEG_9    = 7'h6F;
  localparam logic [6:0] SEG_DASH = 7'h40;
  localparam logic [6:0] SEG_OFF  = 7'h00;

  localparam logic [6:0] MAX_DISPLAY = 7'd99;
  localparam int         SHIFT_STEPS = 7;

  // Active-high segment pattern for a BCD code; BLANK and unused codes are dark.
  function automatic logic [6:0] seg_decode(input logic [3:0] code);
    logic [6:0] seg;
    case (code)
      4'd0:     seg = SEG_0;
      4'd1:     seg = SEG_1;
      4'd2:     seg = SEG_2;
      4'd3:     seg = SEG_3;
      4'd4:     seg = SEG_4;
      4'd5:     seg = SEG_5;
      4'd6:     seg = SEG_6;
      4'd7:     seg = SEG_7;
      4'd8:     seg = SEG_8;
      4'd9:     seg = SEG_9;
      BCD_DASH: seg = SEG_DASH;
      default:  seg = SEG_OFF;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential shift-add-3 converter: 7-bit binary to two BCD digits, one bit per cycle.
// Values above the displayable range commit DASH to both digits after the same latency.
module bin2bcd_seq
  import traffic_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] value_i,
  output logic [3:0] tens_o,
  output logic [3:0] ones_o,
  output logic       busy_o,
  output logic       done_o
);

  conv_state_t state_q, state_d;
  logic [6:0]  cap_q;
  logic [6:0]  bin_q;
  logic [7:0]  bcd_q;
  logic [2:0]  iter_q;
  logic [3:0]  tens_q, ones_q;
  logic        start;
  logic [7:0]  bcd_adj;
  logic [14:0] shifted;

  // Only an idle converter looks at the input, so values seen while busy are dropped.
  assign start = (state_q == IDLE) && (value_i != cap_q);

  always_comb begin
    bcd_adj = bcd_q;
    if (bcd_q[3:0] >= 4'd5) bcd_adj[3:0] = bcd_q[3:0] + 4'd3;
    if (bcd_q[7:4] >= 4'd5) bcd_adj[7:4] = bcd_q[7:4] + 4'd3;
  end

  assign shifted = {bcd_adj, bin_q} << 1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = SHIFT;
      SHIFT:   if (iter_q == 3'(SHIFT_STEPS - 1)) state_d = COMMIT;
      COMMIT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap_q  <= '0;
      bin_q  <= '0;
      bcd_q  <= '0;
      iter_q <= '0;
      tens_q <= '0;
      ones_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            cap_q  <= value_i;
            bin_q  <= value_i;
            bcd_q  <= '0;
            iter_q <= '0;
          end
        end
        SHIFT: begin
          bcd_q  <= shifted[14:7];
          bin_q  <= shifted[6:0];
          iter_q <= iter_q + 3'd1;
        end
        COMMIT: begin
          if (cap_q > MAX_DISPLAY) begin
            tens_q <= BCD_DASH;
            ones_q <= BCD_DASH;
          end else begin
            tens_q <= bcd_q[7:4];
            ones_q <= bcd_q[3:0];
          end
        end
        default: ;
      endcase
    end
  end

  assign tens_o = tens_q;
  assign ones_o = ones_q;
  assign busy_o = (state_q != IDLE);
  assign done_o = (state_q == COMMIT);

endmodule

// File: rtl/countdown_display.sv
// Two-digit multiplexed 7-segment display for the traffic-light seconds counter,
// with leading-zero blanking, over-range dashes and a warning blink.
module countdown_display
  import traffic_pkg::*;
#(
  parameter int pSCAN_DIV    = 1000,
  parameter int pBLINK_SLOTS = 256,
  parameter int pACTIVE_LOW  = 1,
  parameter int pBLANK_LZ    = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en_i,
  input  logic [6:0] value_i,
  input  logic       warn_i,
  output logic [6:0] seg_o,
  output logic [1:0] dig_o,
  output logic       busy_o
);

  localparam int             PW         = (pSCAN_DIV > 1) ? $clog2(pSCAN_DIV) : 1;
  localparam int             BW         = $clog2(pBLINK_SLOTS + 1);
  localparam logic [PW-1:0]  PRESC_LAST = PW'(pSCAN_DIV - 1);
  localparam logic [BW-1:0]  BLINK_LAST = BW'(pBLINK_SLOTS - 1);
  localparam logic           INV        = (pACTIVE_LOW != 0);

  logic [PW-1:0] presc_q;
  logic [BW-1:0] blink_q;
  logic          sel_q;
  logic          phase_q;
  logic [3:0]    tens, ones;
  logic [3:0]    code;
  logic          dark;
  logic [6:0]    seg_q;
  logic [1:0]    dig_q;

  bin2bcd_seq u_conv (
    .clk     (clk),
    .rst_n   (rst_n),
    .value_i (value_i),
    .tens_o  (tens),
    .ones_o  (ones),
    .busy_o  (busy_o),
    .done_o  ()
  );

  // Refresh prescaler; each wrap ends a digit slot and advances the blink timer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q <= '0;
      sel_q   <= 1'b0;
      blink_q <= '0;
      phase_q <= 1'b0;
    end else if (presc_q == PRESC_LAST) begin
      presc_q <= '0;
      sel_q   <= ~sel_q;
      if (blink_q == BLINK_LAST) begin
        blink_q <= '0;
        phase_q <= ~phase_q;
      end else begin
        blink_q <= blink_q + BW'(1);
      end
    end else begin
      presc_q <= presc_q + PW'(1);
    end
  end

  always_comb begin
    code = ones;
    if (sel_q) begin
      code = tens;
      if ((pBLANK_LZ != 0) && (tens == 4'd0)) code = BCD_BLANK;
    end
  end

  assign dark = !en_i || (warn_i && phase_q);

  // Scanning and conversion keep running while dark so re-enabling shows current digits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_q <= {7{INV}};
      dig_q <= {2{INV}};
    end else if (dark) begin
      seg_q <= {7{INV}};
      dig_q <= {2{INV}};
    end else begin
      seg_q <= seg_decode(code) ^ {7{INV}};
      dig_q <= (sel_q ? 2'b10 : 2'b01) ^ {2{INV}};
    end
  end

  assign seg_o = seg_q;
  assign dig_o = dig_q;

endmodule

// File: tb/tb_countdown_display.sv
// Bench for countdown_display: an active-high blanking instance and an active-low
// non-blanking instance share stimulus; committed digits come from a scoreboard queue.
module tb_countdown_display;

  localparam int SCAN  = 4;
  localparam int BLINK = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b1;
  logic       warn = 1'b0;
  logic [6:0] value = 7'd99;
  logic [6:0] seg_a, seg_b;
  logic [1:0] dig_a, dig_b;
  logic       busy_a, busy_b;

  always #5 clk = ~clk;

  countdown_display #(
    .pSCAN_DIV(SCAN), .pBLINK_SLOTS(BLINK), .pACTIVE_LOW(0), .pBLANK_LZ(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en_i(en), .value_i(value), .warn_i(warn),
    .seg_o(seg_a), .dig_o(dig_a), .busy_o(busy_a)
  );

  countdown_display #(
    .pSCAN_DIV(SCAN), .pBLINK_SLOTS(BLINK), .pACTIVE_LOW(1), .pBLANK_LZ(0)
  ) dut_nolz (
    .clk(clk), .rst_n(rst_n), .en_i(en), .value_i(value), .warn_i(warn),
    .seg_o(seg_b), .dig_o(dig_b), .busy_o(busy_b)
  );

  typedef struct {
    int         due;
    logic [6:0] t1, o1, t2, o2;
  } exp_t;

  exp_t       sb[$];
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  int         busy_cnt;
  int         c0;
  logic       busy_prev = 1'b0;
  logic [6:0] t1, o1, t2, o2;

  function automatic logic [6:0] seg_of(input int d);
    case (d)
      0: return 7'h3F;
      1: return 7'h06;
      2: return 7'h5B;
      3: return 7'h4F;
      4: return 7'h66;
      5: return 7'h6D;
      6: return 7'h7D;
      7: return 7'h07;
      8: return 7'h7F;
      9: return 7'h6F;
      default: return 7'h00;
    endcase
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic pushExpect(input int v, input int due);
    exp_t e;
    e.due = due;
    if (v > 99) begin
      e.t1 = 7'h40; e.o1 = 7'h40; e.t2 = 7'h40; e.o2 = 7'h40;
    end else begin
      e.o1 = seg_of(v % 10);
      e.o2 = e.o1;
      e.t2 = seg_of(v / 10);
      e.t1 = (v / 10 == 0) ? 7'h00 : e.t2;
    end
    sb.push_back(e);
  endtask

  // Expected scan/blink position is derived from the edge count since reset release.
  task automatic checkDisplay();
    int         s  = ((cyc - 1) / SCAN) % 2;
    int         ph = ((cyc - 1) / (SCAN * BLINK)) % 2;
    logic [1:0] ed, edn;
    logic [6:0] es1, es2, es2n;
    exp_t       e;
    if (!en || (warn && ph == 1)) begin
      ed = 2'b00; es1 = 7'h00; es2 = 7'h00;
    end else begin
      ed  = (s == 1) ? 2'b10 : 2'b01;
      es1 = (s == 1) ? t1 : o1;
      es2 = (s == 1) ? t2 : o2;
    end
    edn  = ~ed;
    es2n = ~es2;
    checkOutput("dig_a", dig_a, ed);
    checkOutput("seg_a", seg_a, es1);
    checkOutput("dig_b", dig_b, edn);
    checkOutput("seg_b", seg_b, es2n);
    if (sb.size() > 0 && cyc > sb[0].due) begin
      checkOutput("commit_late", cyc, sb[0].due);
      void'(sb.pop_front());
    end
    if (busy_prev && !busy_a) begin
      checkOutput("commit_expected", sb.size() > 0, 1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        checkOutput("commit_cycle", cyc, e.due);
        t1 = e.t1; o1 = e.o1; t2 = e.t2; o2 = e.o2;
      end
    end
    busy_prev = busy_a;
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
    #1;
    checkDisplay();
  endtask

  task automatic applyStimulus(input logic e, input logic w, input logic [6:0] v, input int n);
    en = e; warn = w; value = v;
    repeat (n) tick();
  endtask

  task automatic resetDigits();
    t1 = 7'h00; o1 = 7'h3F; t2 = 7'h3F; o2 = 7'h3F;
    busy_prev = 1'b0;
  endtask

  task automatic checkDark(input string tag);
    checkOutput({tag, "_busy"}, busy_a, 1'b0);
    checkOutput({tag, "_dig_a"}, dig_a, 2'b00);
    checkOutput({tag, "_seg_a"}, seg_a, 7'h00);
    checkOutput({tag, "_dig_b"}, dig_b, 2'b11);
    checkOutput({tag, "_seg_b"}, seg_b, 7'h7F);
  endtask

  initial begin
    resetDigits();
    repeat (3) @(posedge clk);
    #1;
    checkDark("reset");

    // Power-up conversion of 99; busy must span exactly 8 samples.
    @(negedge clk);
    rst_n = 1'b1;
    cyc = 0;
    pushExpect(99, 9);
    busy_cnt = 0;
    en = 1'b1; warn = 1'b0; value = 7'd99;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (busy_a) busy_cnt++;
    end
    checkOutput("busy_len", busy_cnt, 8);
    applyStimulus(1'b1, 1'b0, 7'd99, 24);

    $display("[TB] value 7: tens blanked on one instance only");
    pushExpect(7, cyc + 9);
    applyStimulus(1'b1, 1'b0, 7'd7, 20);

    $display("[TB] value 120: over-range dashes");
    pushExpect(120, cyc + 9);
    applyStimulus(1'b1, 1'b0, 7'd120, 20);

    $display("[TB] 50/49/48 while busy: 49 must never appear");
    c0 = cyc;
    pushExpect(50, c0 + 9);
    applyStimulus(1'b1, 1'b0, 7'd50, 1);
    applyStimulus(1'b1, 1'b0, 7'd49, 1);
    pushExpect(48, c0 + 18);
    applyStimulus(1'b1, 1'b0, 7'd48, 30);

    $display("[TB] warning blink, then steady, then disabled");
    applyStimulus(1'b1, 1'b1, 7'd48, 40);
    applyStimulus(1'b1, 1'b0, 7'd48, 16);
    applyStimulus(1'b0, 1'b0, 7'd48, 12);
    applyStimulus(1'b1, 1'b0, 7'd48, 10);

    $display("[TB] reset asserted mid-conversion");
    pushExpect(33, cyc + 9);
    applyStimulus(1'b1, 1'b0, 7'd33, 3);
    rst_n = 1'b0;
    #1;
    checkDark("midreset");
    sb.delete();
    resetDigits();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    cyc = 0;
    pushExpect(33, 9);
    applyStimulus(1'b1, 1'b0, 7'd33, 20);

    checkOutput("scoreboard_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/countdown_display.md
Name: countdown_display

Overview:
- Downstream consumer of the traffic-light seconds down-counter.
- Takes the 7-bit remaining-seconds value and a warning flag (driven from the counter's pre_last/last).
- Converts the binary value to two BCD digits using a sequential shift-add-3 converter.
- Drives a time-multiplexed two-digit 7-segment display with leading-zero blanking, over-range dashes and warning blink.

Parameters:
- pSCAN_DIV, 1000: clk cycles per digit slot (refresh prescaler); legal range ≥2.
- pBLINK_SLOTS, 256: digit slots per blink half-period.
- pACTIVE_LOW, 1: 1 = seg_o and dig_o are active-low (common anode); 0 = active-high.
- pBLANK_LZ, 1: 1 = blank the tens digit when it is 0.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  reset: asynchronous, active-low.
- en_i  input  1  display enable; 0 = all digits dark.
- value_i  input  7  remaining seconds, binary, 0..127.
- warn_i  input  1  blink request (pre_last | last from the counter).
- seg_o  output  7  segments; bit0 = a … bit6 = g; registered.
- dig_o  output  2  one-hot digit select; bit0 = ones, bit1 = tens; registered.
- busy_o  output  1  converter not in IDLE.

Behaviour:
- Reset values:
  - Captured value cap_q = 0; tens_q = 0, ones_q = 0.
  - FSM = IDLE; prescaler = 0; sel = 0 (ones); blink counter = 0; blink phase = 0.
  - seg_o and dig_o at the inactive level (all 1s when pACTIVE_LOW = 1); busy_o = 0.
- Converter FSM, states IDLE, SHIFT, COMMIT:
  - IDLE: if value_i != cap_q, capture value_i into cap_q, load the shift register (bin = value_i, bcd = 0), clear the iteration count, go to SHIFT. Otherwise stay.
  - SHIFT: each cycle, add 3 to every BCD nibble ≥ 5, then shift {bcd, bin} left by 1. After the 7th shift, go to COMMIT.
  - COMMIT: write tens_q and ones_q, go to IDLE.
  - Latency: tens_q/ones_q update on the 9th rising edge after the capture edge (1 capture + 7 shift + 1 commit).
  - value_i changes while busy are ignored. In IDLE they are re-compared against cap_q, so only the last stable value is converted; intermediate values may be skipped.
  - Over-range: cap_q > 99 commits code DASH (4'hA) to both digits, shown as "--". The shift sequence still runs, so latency is unchanged.
- Scan:
  - Prescaler counts 0..pSCAN_DIV-1 and wraps.
  - On wrap, sel toggles and the blink counter increments.
  - When the blink counter reaches pBLINK_SLOTS-1 it wraps to 0 and blink phase toggles.
- Digit selection for the current slot:
  - sel = 0 shows ones_q.
  - sel = 1 shows tens_q, replaced by BLANK (4'hF) when pBLANK_LZ = 1 and tens_q = 0.
  - A 0-valued number therefore displays as a single "0".
- Decoder: 0–9 standard segments; A = g only; F and any other code = all segments off.
- Output register, updated every cycle:
  - If en_i = 0, or (warn_i = 1 and blink phase = 1): dig_o and seg_o take the inactive level.
  - Otherwise dig_o = one-hot(sel) and seg_o = decode(selected code).
  - Both are XOR-inverted when pACTIVE_LOW = 1.
  - Output lags sel by 1 cycle.
- en_i = 0 does not stop scanning or conversion, so digits are current when re-enabled.
- Mid-operation rst_n assertion clears everything immediately, including an in-flight conversion; the display goes dark.
- Simultaneous COMMIT and scan wrap: the output register uses the new digit values on the following edge. No tearing within a slot beyond one cycle.

Decomposition:
- Shared package traffic_pkg holds:
  - Converter state enum (IDLE/SHIFT/COMMIT).
  - BCD codes: DASH = 4'hA, BLANK = 4'hF.
  - 7-bit segment constants for 0–9, dash and off.
  - Max displayable value: 99.
- One sub-module: bin2bcd_seq, containing the converter FSM, the shift register, start/busy/done and the tens/ones outputs.
- Scan, blink and decode stay in the top level.

Test Plan:
- Release reset with value_i = 99, en_i = 1, pSCAN_DIV = 4, pACTIVE_LOW = 0 → busy_o high for 8 cycles; then dig_o alternates 01/10 every 4 cycles; seg_o = 7'h6F on both digits.
- Step value_i 99 → 7 → tens slot shows dig_o = 10 with seg_o = 0 (leading zero blanked); ones slot shows 7'h07. Repeat with pBLANK_LZ = 0 → tens slot shows 7'h3F.
- value_i = 120 → both slots show seg_o = 7'h40 (dash), 9 cycles after capture.
- Change value_i 50 → 49 → 48 on consecutive cycles during a conversion → final display "48"; 49 is never committed; no glitch to intermediate codes.
- warn_i = 1, pBLINK_SLOTS = 2 → outputs are dark for 8 cycles and lit for 8 cycles, alternating; warn_i = 0 → always lit. en_i = 0 → outputs dark while scan continues.
- Assert rst_n mid-SHIFT → busy_o = 0 and outputs inactive immediately. After release, the conversion restarts from the current value_i.
